// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Runs only after the PLL lock has
//               been stable for SETTLE_CYCLES, and restarts a fresh frame on
//               every lock recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit SYNC_POL      = 1'b0,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic       running
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Widths can also represent the totals, so sync-end bounds never truncate
    localparam int c_HW      = $clog2(c_H_TOTAL + 1);
    localparam int c_VW      = $clog2(c_V_TOTAL + 1);
    localparam int c_SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int c_PIX_W   = 10;

    localparam logic [c_HW-1:0] c_H_LAST     = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_ACT      = c_HW'(H_ACTIVE);
    localparam logic [c_HW-1:0] c_HS_START   = c_HW'(H_ACTIVE + H_FP);
    localparam logic [c_HW-1:0] c_HS_END     = c_HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [c_VW-1:0] c_V_LAST     = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT      = c_VW'(V_ACTIVE);
    localparam logic [c_VW-1:0] c_VS_START   = c_VW'(V_ACTIVE + V_FP);
    localparam logic [c_VW-1:0] c_VS_END     = c_VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [c_SW-1:0] c_SETTLE_END = c_SW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_WAIT_LOCK = 2'd0;
    localparam logic [1:0] c_SETTLE    = 2'd1;
    localparam logic [1:0] c_RUN       = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_SW-1:0] r_settle_cnt;
    logic [c_SW-1:0] w_settle_nxt;
    logic [c_HW-1:0] r_h_cnt;
    logic [c_HW-1:0] w_h_nxt;
    logic [c_VW-1:0] r_v_cnt;
    logic [c_VW-1:0] w_v_nxt;
    logic            w_run_nxt;
    logic            w_de_nxt;
    logic            w_hs_act;
    logic            w_vs_act;

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle_cnt;
        case (r_state)
            c_WAIT_LOCK: begin
                if (pll_locked) begin
                    w_state_nxt  = c_SETTLE;
                    w_settle_nxt = '0;
                end
            end
            c_SETTLE: begin
                if (!pll_locked) begin
                    w_state_nxt = c_WAIT_LOCK;
                end else if (r_settle_cnt == c_SETTLE_END) begin
                    w_state_nxt = c_RUN;
                end else begin
                    w_settle_nxt = r_settle_cnt + c_SW'(1);
                end
            end
            c_RUN: begin
                if (!pll_locked) begin
                    w_state_nxt = c_WAIT_LOCK;
                end
            end
            default: w_state_nxt = c_WAIT_LOCK;
        endcase
    end

    // Counters only advance while staying in RUN; any entry into RUN starts at 0,0
    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (r_state == c_RUN && w_state_nxt == c_RUN) begin
            if (r_h_cnt == c_H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_VW'(1);
            end else begin
                w_h_nxt = r_h_cnt + c_HW'(1);
                w_v_nxt = r_v_cnt;
            end
        end
    end

    // Outputs are decoded from next-cycle counters so they register in step with them
    assign w_run_nxt = (w_state_nxt == c_RUN);
    assign w_de_nxt  = w_run_nxt && (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
    assign w_hs_act  = w_run_nxt && (w_h_nxt >= c_HS_START) && (w_h_nxt < c_HS_END);
    assign w_vs_act  = w_run_nxt && (w_v_nxt >= c_VS_START) && (w_v_nxt < c_VS_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_WAIT_LOCK;
            r_settle_cnt <= '0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            hsync        <= ~SYNC_POL;
            vsync        <= ~SYNC_POL;
            de           <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            running      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            hsync        <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            vsync        <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            de           <= w_de_nxt;
            pix_x        <= w_de_nxt ? c_PIX_W'(w_h_nxt) : '0;
            pix_y        <= w_de_nxt ? c_PIX_W'(w_v_nxt) : '0;
            line_start   <= w_run_nxt && (w_h_nxt == '0);
            frame_start  <= w_run_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
            running      <= w_run_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench: two small-raster instances (both sync
//               polarities) and one default-parameter instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    // Small raster: H 8+2+3+2 = 15, V 4+1+2+1 = 8, frame = 120 clocks
    localparam int c_SC      = 16;
    localparam int c_HT      = 15;
    localparam int c_VT      = 8;
    localparam int c_FRAME   = 120;
    localparam int c_DEF_SC  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;

    logic       hsync, vsync, de, line_start, frame_start, running;
    logic [9:0] pix_x, pix_y;
    logic       hsync_p, vsync_p, de_p, line_start_p, frame_start_p, running_p;
    logic [9:0] pix_x_p, pix_y_p;
    logic       hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
    logic [9:0] pix_x_d, pix_y_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .SETTLE_CYCLES(c_SC)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start), .running(running)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1), .SETTLE_CYCLES(c_SC)
    ) dut_p (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync_p), .vsync(vsync_p), .de(de_p), .pix_x(pix_x_p), .pix_y(pix_y_p),
        .line_start(line_start_p), .frame_start(frame_start_p), .running(running_p)
    );

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pll_locked(pll_locked),
        .hsync(hsync_d), .vsync(vsync_d), .de(de_d), .pix_x(pix_x_d), .pix_y(pix_y_d),
        .line_start(line_start_d), .frame_start(frame_start_d), .running(running_d)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(); tick();
        checks++; if (running !== 1'b0 || de !== 1'b0 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: running=%b de=%b ls=%b fs=%b, expected all 0", running, de, line_start, frame_start);
        end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL reset_sync_pol0: hsync=%b vsync=%b, expected 1 1", hsync, vsync);
        end
        checks++; if (hsync_p !== 1'b0 || vsync_p !== 1'b0) begin
            errors++; $display("FAIL reset_sync_pol1: hsync=%b vsync=%b, expected 0 0", hsync_p, vsync_p);
        end
        checks++; if (pix_x !== 10'd0 || pix_y !== 10'd0) begin
            errors++; $display("FAIL reset_pix: pix_x=%0d pix_y=%0d, expected 0 0", pix_x, pix_y);
        end
        // reset must win over a lock indication
        pll_locked = 1'b1;
        tick(); tick();
        checks++; if (running !== 1'b0 || hsync !== 1'b1) begin
            errors++; $display("FAIL reset_priority: running=%b hsync=%b, expected 0 1", running, hsync);
        end
    endtask

    // Entered with pll_locked = 1; releases reset on the first locked cycle
    task automatic test_settle();
        rst = 1'b0;
        for (int i = 1; i <= c_SC; i++) begin
            tick();
            checks++; if (running !== 1'b0) begin
                errors++; $display("FAIL settle_early: cycle %0d running=%b, expected 0", i, running);
            end
        end
        tick();
        checks++; if (running !== 1'b1 || running_p !== 1'b1) begin
            errors++; $display("FAIL settle_run: running=%b running_p=%b, expected 1 1", running, running_p);
        end
        checks++; if (frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1) begin
            errors++; $display("FAIL settle_first: fs=%b ls=%b de=%b, expected 1 1 1", frame_start, line_start, de);
        end
    endtask

    // Entered on the first RUN cycle (h=0, v=0); covers two whole frames
    task automatic test_frame_timing();
        int eh, ev, fs_n, fs_first, fs_second, ls_last, de_n;
        logic exp_de, exp_hs, exp_vs;
        eh = 0; ev = 0; fs_n = 0; fs_first = -1; fs_second = -1; ls_last = -1; de_n = 0;
        for (int c = 0; c < 2 * c_FRAME; c++) begin
            exp_de = (eh < 8) && (ev < 4);
            exp_hs = (eh >= 10) && (eh < 13);
            exp_vs = (ev >= 5) && (ev < 7);
            checks++; if (de !== exp_de) begin
                errors++; $display("FAIL de h=%0d v=%0d: got %b expected %b", eh, ev, de, exp_de);
            end
            checks++; if (pix_x !== 10'(exp_de ? eh : 0) || pix_y !== 10'(exp_de ? ev : 0)) begin
                errors++; $display("FAIL pix h=%0d v=%0d: got %0d,%0d expected %0d,%0d", eh, ev, pix_x, pix_y,
                                   exp_de ? eh : 0, exp_de ? ev : 0);
            end
            checks++; if (hsync !== ~exp_hs || vsync !== ~exp_vs) begin
                errors++; $display("FAIL sync_pol0 h=%0d v=%0d: got %b%b expected %b%b", eh, ev, hsync, vsync, ~exp_hs, ~exp_vs);
            end
            checks++; if (hsync_p !== exp_hs || vsync_p !== exp_vs) begin
                errors++; $display("FAIL sync_pol1 h=%0d v=%0d: got %b%b expected %b%b", eh, ev, hsync_p, vsync_p, exp_hs, exp_vs);
            end
            checks++; if (line_start !== (eh == 0) || frame_start !== (eh == 0 && ev == 0)) begin
                errors++; $display("FAIL pulses h=%0d v=%0d: ls=%b fs=%b", eh, ev, line_start, frame_start);
            end
            if (line_start === 1'b1) begin
                if (ls_last >= 0) begin
                    checks++; if (c - ls_last !== c_HT) begin
                        errors++; $display("FAIL line_period: got %0d expected %0d", c - ls_last, c_HT);
                    end
                end
                ls_last = c;
            end
            if (frame_start === 1'b1) begin
                fs_n++;
                if (fs_first < 0) fs_first = c; else fs_second = c;
            end
            if (de === 1'b1 && c < c_FRAME) de_n++;
            tick();
            eh++;
            if (eh == c_HT) begin eh = 0; ev = (ev + 1) % c_VT; end
        end
        checks++; if (fs_n !== 2 || fs_second - fs_first !== c_FRAME) begin
            errors++; $display("FAIL frame_period: %0d pulses gap %0d, expected 2 gap %0d", fs_n, fs_second - fs_first, c_FRAME);
        end
        checks++; if (de_n !== 32) begin
            errors++; $display("FAIL de_count: got %0d expected 32", de_n);
        end
    endtask

    // Entered at h=0, v=0; drops lock with both syncs active
    task automatic test_lock_loss();
        for (int i = 0; i < 5 * c_HT + 11; i++) tick();
        checks++; if (hsync !== 1'b0 || vsync !== 1'b0) begin
            errors++; $display("FAIL pre_loss_sync: hsync=%b vsync=%b, expected 0 0", hsync, vsync);
        end
        pll_locked = 1'b0;
        tick();
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || hsync_p !== 1'b0 || vsync_p !== 1'b0) begin
            errors++; $display("FAIL loss_sync_idle: %b%b %b%b, expected 11 00", hsync, vsync, hsync_p, vsync_p);
        end
        checks++; if (running !== 1'b0 || de !== 1'b0 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            errors++; $display("FAIL loss_idle: running=%b de=%b pix=%0d,%0d, expected 0 0 0,0", running, de, pix_x, pix_y);
        end
        tick();
        pll_locked = 1'b1;
        for (int i = 0; i < c_SC; i++) tick();
        checks++; if (running !== 1'b0) begin
            errors++; $display("FAIL relock_early: running=%b expected 0", running);
        end
        tick();
        checks++; if (running !== 1'b1 || frame_start !== 1'b1 || pix_x !== 10'd0 || pix_y !== 10'd0) begin
            errors++; $display("FAIL relock_first: running=%b fs=%b pix=%0d,%0d, expected 1 1 0,0", running, frame_start, pix_x, pix_y);
        end
        tick();
        checks++; if (pix_x !== 10'd1 || line_start !== 1'b0) begin
            errors++; $display("FAIL relock_second: pix_x=%0d ls=%b, expected 1 0", pix_x, line_start);
        end
    endtask

    // Entered in RUN; aborts a settle after 8 counts
    task automatic test_settle_abort();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        for (int i = 0; i < c_SC; i++) tick();
        checks++; if (running !== 1'b0) begin
            errors++; $display("FAIL abort_full_settle: running=%b expected 0", running);
        end
        tick();
        checks++; if (running !== 1'b1 || frame_start !== 1'b1) begin
            errors++; $display("FAIL abort_run: running=%b fs=%b, expected 1 1", running, frame_start);
        end
    endtask

    // Entered on the first RUN cycle; resets with both syncs active
    task automatic test_reset_midframe();
        for (int i = 0; i < 5 * c_HT + 11; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || hsync_p !== 1'b0 || vsync_p !== 1'b0) begin
            errors++; $display("FAIL midrst_sync: %b%b %b%b, expected 11 00", hsync, vsync, hsync_p, vsync_p);
        end
        checks++; if (running !== 1'b0 || de !== 1'b0 || line_start !== 1'b0) begin
            errors++; $display("FAIL midrst_idle: running=%b de=%b ls=%b, expected 0 0 0", running, de, line_start);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < c_SC; i++) tick();
        checks++; if (running !== 1'b0) begin
            errors++; $display("FAIL midrst_early: running=%b expected 0", running);
        end
        tick();
        checks++; if (running !== 1'b1 || frame_start !== 1'b1) begin
            errors++; $display("FAIL midrst_run: running=%b fs=%b, expected 1 1", running, frame_start);
        end
    endtask

    // 640x480 defaults: settle latency and one full line
    task automatic test_default_params();
        logic exp_de, exp_hs;
        rst = 1'b1;
        pll_locked = 1'b0;
        tick(); tick();
        checks++; if (hsync_d !== 1'b1 || running_d !== 1'b0) begin
            errors++; $display("FAIL def_reset: hsync=%b running=%b, expected 1 0", hsync_d, running_d);
        end
        rst = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < c_DEF_SC; i++) tick();
        checks++; if (running_d !== 1'b0) begin
            errors++; $display("FAIL def_settle_early: running=%b expected 0", running_d);
        end
        tick();
        checks++; if (running_d !== 1'b1 || frame_start_d !== 1'b1 || de_d !== 1'b1 || pix_y_d !== 10'd0) begin
            errors++; $display("FAIL def_first: running=%b fs=%b de=%b pix_y=%0d, expected 1 1 1 0", running_d, frame_start_d, de_d, pix_y_d);
        end
        for (int h = 0; h < 800; h++) begin
            exp_de = (h < 640);
            exp_hs = (h >= 656) && (h < 752);
            checks++; if (de_d !== exp_de || pix_x_d !== 10'(exp_de ? h : 0)) begin
                errors++; $display("FAIL def_de h=%0d: de=%b pix_x=%0d", h, de_d, pix_x_d);
            end
            checks++; if (hsync_d !== ~exp_hs || vsync_d !== 1'b1 || line_start_d !== (h == 0)) begin
                errors++; $display("FAIL def_sync h=%0d: hsync=%b vsync=%b ls=%b", h, hsync_d, vsync_d, line_start_d);
            end
            tick();
        end
        checks++; if (line_start_d !== 1'b1 || frame_start_d !== 1'b0 || pix_y_d !== 10'd1) begin
            errors++; $display("FAIL def_line1: ls=%b fs=%b pix_y=%0d, expected 1 0 1", line_start_d, frame_start_d, pix_y_d);
        end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_frame_timing();
        test_lock_loss();
        test_settle_abort();
        test_reset_midframe();
        test_default_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
